// File: rtl/bound_write_ctrl_pkg.sv
// Shared constants and state encoding for the character bound write controller.
package bound_write_ctrl_pkg;

  localparam int unsigned NUMBER_OF_CHAR_DEF = 8;
  localparam int unsigned COORD_W_DEF        = 16;
  localparam int unsigned ADDR_W             = 3;
  localparam int unsigned CNT_W              = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MIN  = 3'd1,
    ST_MAX  = 3'd2,
    ST_GAP1 = 3'd3,
    ST_GAP2 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/bound_write_ctrl.sv
// Turns segmenter character bounds into paired min/max writes to the bound store,
// with the two idle cycles the store needs between pairs, plus an independent row path.
module bound_write_ctrl
  import bound_write_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_OF_CHAR = NUMBER_OF_CHAR_DEF,
  parameter int unsigned COORD_W        = COORD_W_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               frame_start,
  input  logic               seg_valid,
  output logic               seg_ready,
  input  logic [COORD_W-1:0] seg_x_min,
  input  logic [COORD_W-1:0] seg_x_max,
  input  logic               seg_last,
  input  logic               y_valid,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] bound_y_min,
  output logic [COORD_W-1:0] bound_y_max,
  output logic               bound_y_min_we,
  output logic               bound_y_max_we,
  output logic [ADDR_W-1:0]  bound_x_min_addr,
  output logic [ADDR_W-1:0]  bound_x_max_addr,
  output logic [COORD_W-1:0] bound_x_min,
  output logic [COORD_W-1:0] bound_x_max,
  output logic               bound_x_min_we,
  output logic               bound_x_max_we,
  output logic               clr,
  output logic [CNT_W-1:0]   char_count,
  output logic               frame_done,
  output logic               overflow
);

  state_t             r_state,      w_state_nxt;
  logic               r_seg_ready,  w_seg_ready_nxt;
  logic               r_x_min_we,   w_x_min_we_nxt;
  logic               r_x_max_we,   w_x_max_we_nxt;
  logic               r_clr,        w_clr_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_overflow,   w_overflow_nxt;
  logic               r_pending,    w_pending_nxt;
  logic               r_last,       w_last_nxt;
  logic [CNT_W-1:0]   r_char_count, w_char_count_nxt;
  logic [ADDR_W-1:0]  r_addr,       w_addr_nxt;
  logic [COORD_W-1:0] r_x_min,      w_x_min_nxt;
  logic [COORD_W-1:0] r_x_max,      w_x_max_nxt;

  logic [COORD_W-1:0] r_y_min;
  logic [COORD_W-1:0] r_y_max;
  logic               r_y_we;

  logic w_xfer;
  logic w_full;
  logic w_swap;
  logic w_restart;

  // frame_start has priority over a character offered in the same IDLE cycle
  assign w_xfer  = (r_state == ST_IDLE) && seg_valid && r_seg_ready && !frame_start;
  assign w_full  = (r_char_count == CNT_W'(NUMBER_OF_CHAR));
  assign w_swap  = (seg_x_max < seg_x_min);

  // Restart only where a pair cannot be split: IDLE, DONE, or at the end of GAP2
  assign w_restart = (frame_start && ((r_state == ST_IDLE) || (r_state == ST_DONE))) ||
                     ((r_state == ST_GAP2) && (r_pending || frame_start));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_seg_ready_nxt  = 1'b0;
    w_x_min_we_nxt   = 1'b0;
    w_x_max_we_nxt   = 1'b0;
    w_clr_nxt        = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_overflow_nxt   = r_overflow;
    w_pending_nxt    = r_pending;
    w_last_nxt       = r_last;
    w_char_count_nxt = r_char_count;
    w_addr_nxt       = r_addr;
    w_x_min_nxt      = r_x_min;
    w_x_max_nxt      = r_x_max;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_full) begin
          // Table full: accept and drop so upstream never stalls
          w_overflow_nxt = 1'b1;
          if (seg_last) begin
            w_state_nxt      = ST_DONE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_seg_ready_nxt  = 1'b1;
          end
        end else if (w_xfer) begin
          w_x_min_nxt    = w_swap ? seg_x_max : seg_x_min;
          w_x_max_nxt    = w_swap ? seg_x_min : seg_x_max;
          w_addr_nxt     = r_char_count[ADDR_W-1:0];
          w_last_nxt     = seg_last;
          w_x_min_we_nxt = 1'b1;
          w_state_nxt    = ST_MIN;
        end else begin
          w_seg_ready_nxt = 1'b1;
        end
      end
      ST_MIN: begin
        w_pending_nxt  = r_pending | frame_start;
        w_x_max_we_nxt = 1'b1;
        w_state_nxt    = ST_MAX;
      end
      ST_MAX: begin
        w_pending_nxt    = r_pending | frame_start;
        w_char_count_nxt = r_char_count + CNT_W'(1);
        w_state_nxt      = ST_GAP1;
      end
      ST_GAP1: begin
        w_pending_nxt = r_pending | frame_start;
        w_state_nxt   = ST_GAP2;
      end
      ST_GAP2: begin
        if (r_last) begin
          w_state_nxt      = ST_DONE;
          w_frame_done_nxt = 1'b1;
        end else begin
          w_state_nxt      = ST_IDLE;
          w_seg_ready_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_restart) begin
      w_state_nxt      = ST_IDLE;
      w_seg_ready_nxt  = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_clr_nxt        = 1'b1;
      w_char_count_nxt = '0;
      w_overflow_nxt   = 1'b0;
      w_pending_nxt    = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_seg_ready  <= 1'b0;
      r_x_min_we   <= 1'b0;
      r_x_max_we   <= 1'b0;
      r_clr        <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_pending    <= 1'b0;
      r_last       <= 1'b0;
      r_char_count <= '0;
      r_addr       <= '0;
      r_x_min      <= '0;
      r_x_max      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_seg_ready  <= w_seg_ready_nxt;
      r_x_min_we   <= w_x_min_we_nxt;
      r_x_max_we   <= w_x_max_we_nxt;
      r_clr        <= w_clr_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overflow   <= w_overflow_nxt;
      r_pending    <= w_pending_nxt;
      r_last       <= w_last_nxt;
      r_char_count <= w_char_count_nxt;
      r_addr       <= w_addr_nxt;
      r_x_min      <= w_x_min_nxt;
      r_x_max      <= w_x_max_nxt;
    end
  end

  // Row bounds bypass the FSM entirely
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_y_min <= '0;
      r_y_max <= '0;
      r_y_we  <= 1'b0;
    end else begin
      r_y_we <= y_valid;
      if (y_valid) begin
        r_y_min <= y_min;
        r_y_max <= y_max;
      end
    end
  end

  assign seg_ready        = r_seg_ready;
  assign bound_y_min      = r_y_min;
  assign bound_y_max      = r_y_max;
  assign bound_y_min_we   = r_y_we;
  assign bound_y_max_we   = r_y_we;
  assign bound_x_min_addr = r_addr;
  assign bound_x_max_addr = r_addr;
  assign bound_x_min      = r_x_min;
  assign bound_x_max      = r_x_max;
  assign bound_x_min_we   = r_x_min_we;
  assign bound_x_max_we   = r_x_max_we;
  assign clr              = r_clr;
  assign char_count       = r_char_count;
  assign frame_done       = r_frame_done;
  assign overflow         = r_overflow;

endmodule
